// File: rtl/nx_srfram_indirect_access_mt_pkg.sv
// Shared types for the multi-table SRFRAM indirect-access controller.
//   ind_op_e     : software indirect command opcodes
//   stat_code_e  : command status reported back to software
//   ctl_state_e  : controller FSM states
//   idx_w()      : index width for a count of items (minimum 1 bit)
package nx_srfram_indirect_access_mt_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_READ  = 4'd1,
    OP_WRITE = 4'd2,
    OP_FILL  = 4'd3,
    OP_INIT  = 4'd4
  } ind_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_BUSY      = 3'd1,
    ST_OK        = 3'd2,
    ST_ERR_OP    = 3'd3,
    ST_ERR_RANGE = 3'd4
  } stat_code_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RDCAP  = 3'd2,
    S_FILL   = 3'd3,
    S_DONE   = 3'd4
  } ctl_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nx_srfram_indirect_access_mt_if.sv
// Command/status and hardware-client bundle of the indirect-access controller.
//   cmnd_*, wr_dat          : software command (stb is a one-cycle launch pulse)
//   rd_dat, stat_*          : software result/status
//   hw_cs/re/we, hw_*addr,
//   hw_table_id, hw_din     : hardware client access request
//   hw_dout, hw_yield,
//   hw_drop                 : hardware client read data and arbitration feedback
// Modports: master = software/hardware clients, slave = controller.
interface nx_srfram_indirect_access_mt_if #(
  parameter int N_DATA_BITS = 32,
  parameter int AW          = 6,
  parameter int TW          = 1
) ();

  logic                   cmnd_stb;
  logic [3:0]             cmnd_op;
  logic [AW-1:0]          cmnd_addr;
  logic [TW-1:0]          cmnd_table_id;
  logic [N_DATA_BITS-1:0] wr_dat;
  logic [N_DATA_BITS-1:0] rd_dat;
  logic [2:0]             stat_code;
  logic [AW-1:0]          stat_addr;
  logic [TW-1:0]          stat_table_id;

  logic                   hw_cs;
  logic                   hw_re;
  logic                   hw_we;
  logic [TW-1:0]          hw_table_id;
  logic [AW-1:0]          hw_raddr;
  logic [AW-1:0]          hw_waddr;
  logic [N_DATA_BITS-1:0] hw_din;
  logic [N_DATA_BITS-1:0] hw_dout;
  logic                   hw_yield;
  logic                   hw_drop;

  modport master (
    output cmnd_stb, cmnd_op, cmnd_addr, cmnd_table_id, wr_dat,
    input  rd_dat, stat_code, stat_addr, stat_table_id,
    output hw_cs, hw_re, hw_we, hw_table_id, hw_raddr, hw_waddr, hw_din,
    input  hw_dout, hw_yield, hw_drop
  );

  modport slave (
    input  cmnd_stb, cmnd_op, cmnd_addr, cmnd_table_id, wr_dat,
    output rd_dat, stat_code, stat_addr, stat_table_id,
    input  hw_cs, hw_re, hw_we, hw_table_id, hw_raddr, hw_waddr, hw_din,
    output hw_dout, hw_yield, hw_drop
  );

endinterface

// File: rtl/nx_srfram_indirect_access_mt_starve_timer.sv
// nx_starve_timer: saturating starvation counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : count one cycle of starvation
//   sat      : high while the counter is all-ones; the owner is expected to
//              clear it in that cycle, which makes sat a single-cycle pulse
module nx_starve_timer #(
  parameter int N_TIMER_BITS = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sat
);

  logic [N_TIMER_BITS-1:0] cnt_p0;

  assign sat = &cnt_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (en && !sat) begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

endmodule

// File: rtl/nx_srfram_indirect_access_mt.sv
// Multi-table indirect-access controller for simple-dual-port register-file
// RAM banks instantiated by the parent. Arbitrates one hardware client
// against software READ/WRITE/FILL/INIT commands; a starvation timer forces
// the hardware client to yield one cycle when software has waited too long.
//   clk, rst   : clock, asynchronous active-high reset
//   ctl        : command/status + hardware client bundle (slave side)
//   mem_sel    : one-hot bank select (all ones during INIT)
//   mem_re/we  : read/write enables; mem_ra/mem_wa addresses; mem_din data
//   mem_dout   : concatenated bank read data, bank k at [k*N_DATA_BITS +: N_DATA_BITS]
module nx_srfram_indirect_access_mt
  import nx_srfram_indirect_access_mt_pkg::*;
#(
  parameter int                     N_DATA_BITS  = 32,
  parameter int                     N_ENTRIES    = 64,
  parameter int                     N_TABLES     = 2,
  parameter int                     N_TIMER_BITS = 6,
  parameter logic [N_DATA_BITS-1:0] RESET_DATA   = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  nx_srfram_indirect_access_mt_if.slave   ctl,
  output logic [N_TABLES-1:0]             mem_sel,
  output logic                            mem_re,
  output logic                            mem_we,
  output logic [idx_w(N_ENTRIES)-1:0]     mem_ra,
  output logic [idx_w(N_ENTRIES)-1:0]     mem_wa,
  output logic [N_DATA_BITS-1:0]          mem_din,
  input  logic [N_TABLES*N_DATA_BITS-1:0] mem_dout
);

  localparam int AW = idx_w(N_ENTRIES);
  localparam int TW = idx_w(N_TABLES);

  function automatic logic [N_TABLES-1:0] onehot(input logic [TW-1:0] id);
    onehot = '0;
    for (int k = 0; k < N_TABLES; k++) begin
      if (32'(id) == 32'(k)) onehot[k] = 1'b1;
    end
  endfunction

  // Out-of-range table ids read as zero rather than an undefined slice.
  function automatic logic [N_DATA_BITS-1:0] bank_word(
    input logic [N_TABLES*N_DATA_BITS-1:0] bus,
    input logic [TW-1:0]                   id
  );
    bank_word = '0;
    for (int k = 0; k < N_TABLES; k++) begin
      if (32'(id) == 32'(k)) bank_word = bus[k*N_DATA_BITS +: N_DATA_BITS];
    end
  endfunction

  ctl_state_e             state, state_nxt;
  stat_code_e             stat_p0, code_p0, strobe_code;
  logic [3:0]             op_p0;
  logic [AW-1:0]          addr_p0;
  logic [AW-1:0]          fill_addr_p0;
  logic [TW-1:0]          tid_p0;
  logic [N_DATA_BITS-1:0] dat_p0;
  logic [N_DATA_BITS-1:0] rd_dat_p0;
  logic [TW-1:0]          hw_tid_p1;
  logic                   hw_drop_p0;

  logic sw_need, sw_grant, sw_go, fill_last, hw_yield;
  logic op_legal, in_range, launch;

  // Command decode (IDLE only)
  assign launch   = (state == S_IDLE) && ctl.cmnd_stb;
  assign op_legal = (ctl.cmnd_op <= OP_INIT);
  assign in_range = (ctl.cmnd_op == OP_INIT) ||
                    ((32'(ctl.cmnd_addr) < 32'(N_ENTRIES)) &&
                     (32'(ctl.cmnd_table_id) < 32'(N_TABLES)));

  always_comb begin
    strobe_code = ST_OK;
    if (!op_legal)      strobe_code = ST_ERR_OP;
    else if (!in_range) strobe_code = ST_ERR_RANGE;
  end

  // Arbitration: software only competes for the RAM in ACCESS and FILL.
  assign sw_need   = (state == S_ACCESS) || (state == S_FILL);
  assign sw_grant  = !ctl.hw_cs || hw_yield;
  assign sw_go     = sw_need && sw_grant;
  assign fill_last = (32'(fill_addr_p0) == 32'(N_ENTRIES - 1));

  nx_starve_timer #(
    .N_TIMER_BITS (N_TIMER_BITS)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .clr ((state == S_IDLE) || sw_go),
    .en  (sw_need && ctl.hw_cs),
    .sat (hw_yield)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_sel   = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_ra    = ctl.hw_raddr;
    mem_wa    = ctl.hw_waddr;
    mem_din   = ctl.hw_din;

    case (state)
      S_IDLE: begin
        if (ctl.cmnd_stb && (ctl.cmnd_op != OP_NOP)) begin
          if (strobe_code != ST_OK)
            state_nxt = S_DONE;
          else if ((ctl.cmnd_op == OP_READ) || (ctl.cmnd_op == OP_WRITE))
            state_nxt = S_ACCESS;
          else
            state_nxt = S_FILL;
        end
      end
      S_ACCESS: if (sw_go) state_nxt = (op_p0 == OP_READ) ? S_RDCAP : S_DONE;
      S_RDCAP:  state_nxt = S_DONE;
      S_FILL:   if (sw_go && fill_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase

    // Software owns the bus on a granted cycle; otherwise the hardware
    // client passes straight through (except while it is forced to yield).
    if (sw_go) begin
      if (state == S_ACCESS) begin
        mem_sel = onehot(tid_p0);
        mem_re  = (op_p0 == OP_READ);
        mem_we  = (op_p0 == OP_WRITE);
        mem_ra  = addr_p0;
        mem_wa  = addr_p0;
        mem_din = dat_p0;
      end else begin
        mem_sel = (op_p0 == OP_INIT) ? {N_TABLES{1'b1}} : onehot(tid_p0);
        mem_we  = 1'b1;
        mem_ra  = fill_addr_p0;
        mem_wa  = fill_addr_p0;
        mem_din = dat_p0;
      end
    end else if (ctl.hw_cs && !hw_yield) begin
      mem_sel = onehot(ctl.hw_table_id);
      mem_re  = ctl.hw_re;
      mem_we  = ctl.hw_we;
    end
  end

  // Stage p0: command capture, status, fill counter, read capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_p0      <= ST_IDLE;
      code_p0      <= ST_OK;
      op_p0        <= '0;
      addr_p0      <= '0;
      tid_p0       <= '0;
      fill_addr_p0 <= '0;
      rd_dat_p0    <= '0;
      hw_drop_p0   <= 1'b0;
    end else begin
      if (launch) begin
        op_p0        <= ctl.cmnd_op;
        addr_p0      <= ctl.cmnd_addr;
        tid_p0       <= ctl.cmnd_table_id;
        code_p0      <= strobe_code;
        fill_addr_p0 <= '0;
        stat_p0      <= (ctl.cmnd_op == OP_NOP) ? ST_OK : ST_BUSY;
      end
      if (state == S_DONE) stat_p0 <= code_p0;
      if ((state == S_FILL) && sw_go && !fill_last) fill_addr_p0 <= fill_addr_p0 + 1'b1;
      if (state == S_RDCAP) rd_dat_p0 <= bank_word(mem_dout, tid_p0);
      if (hw_yield && ctl.hw_cs) hw_drop_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (launch) dat_p0 <= (ctl.cmnd_op == OP_INIT) ? RESET_DATA : ctl.wr_dat;
  end

  // Stage p1: hardware read data select follows the RAM's one-cycle latency
  always_ff @(posedge clk) begin
    hw_tid_p1 <= ctl.hw_table_id;
  end

  assign ctl.rd_dat        = rd_dat_p0;
  assign ctl.stat_code     = stat_p0;
  assign ctl.stat_addr     = addr_p0;
  assign ctl.stat_table_id = tid_p0;
  assign ctl.hw_yield      = hw_yield;
  assign ctl.hw_drop       = hw_drop_p0;
  assign ctl.hw_dout       = bank_word(mem_dout, hw_tid_p1);

endmodule

// File: tb/tb_nx_srfram_indirect_access_mt.sv
// Directed bench for nx_srfram_indirect_access_mt with three behavioural
// RAM banks (48 entries each, so out-of-range address/table ids exist).
module tb_nx_srfram_indirect_access_mt;
  import nx_srfram_indirect_access_mt_pkg::*;

  localparam int DW = 32;
  localparam int NE = 48;
  localparam int NT = 3;
  localparam int AW = 6;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nx_srfram_indirect_access_mt_if #(.N_DATA_BITS(DW), .AW(AW), .TW(TW)) ctl ();

  logic [NT-1:0]    mem_sel;
  logic             mem_re, mem_we;
  logic [AW-1:0]    mem_ra, mem_wa;
  logic [DW-1:0]    mem_din;
  logic [NT*DW-1:0] mem_dout = '0;

  nx_srfram_indirect_access_mt #(
    .N_DATA_BITS (DW),
    .N_ENTRIES   (NE),
    .N_TABLES    (NT),
    .N_TIMER_BITS(6),
    .RESET_DATA  (32'h0000_005A)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctl     (ctl),
    .mem_sel (mem_sel),
    .mem_re  (mem_re),
    .mem_we  (mem_we),
    .mem_ra  (mem_ra),
    .mem_wa  (mem_wa),
    .mem_din (mem_din),
    .mem_dout(mem_dout)
  );

  // Behavioural banks: synchronous read, read-before-write.
  logic [DW-1:0] ram [NT][NE];
  always @(posedge clk) begin
    for (int k = 0; k < NT; k++) begin
      if (mem_sel[k] && mem_re && (int'(mem_ra) < NE)) mem_dout[k*DW +: DW] <= ram[k][mem_ra];
      if (mem_sel[k] && mem_we && (int'(mem_wa) < NE)) ram[k][mem_wa] <= mem_din;
    end
  end

  int act_cnt = 0, we_all_cnt = 0, we_t0_cnt = 0;
  always @(negedge clk) begin
    if (mem_re || mem_we)                act_cnt    <= act_cnt + 1;
    if (mem_we && (mem_sel == 3'b111))   we_all_cnt <= we_all_cnt + 1;
    if (mem_we && (mem_sel == 3'b001))   we_t0_cnt  <= we_t0_cnt + 1;
  end

  int n_total = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [AW-1:0] a, input logic [TW-1:0] t,
                     input logic [DW-1:0] d);
    ctl.cmnd_stb      = 1'b1;
    ctl.cmnd_op       = op;
    ctl.cmnd_addr     = a;
    ctl.cmnd_table_id = t;
    ctl.wr_dat        = d;
    tick();
    ctl.cmnd_stb      = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while ((ctl.stat_code == ST_BUSY) && (n < 300)) begin
      tick();
      n++;
    end
  endtask

  task automatic hw_rd(input logic [TW-1:0] t, input logic [AW-1:0] a, output logic [DW-1:0] v);
    ctl.hw_cs       = 1'b1;
    ctl.hw_re       = 1'b1;
    ctl.hw_table_id = t;
    ctl.hw_raddr    = a;
    tick();
    v               = ctl.hw_dout;
    ctl.hw_cs       = 1'b0;
    ctl.hw_re       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base, base2;
    logic [DW-1:0] v;

    ctl.cmnd_stb = 0; ctl.cmnd_op = 0; ctl.cmnd_addr = 0; ctl.cmnd_table_id = 0; ctl.wr_dat = 0;
    ctl.hw_cs = 0; ctl.hw_re = 0; ctl.hw_we = 0; ctl.hw_table_id = 0;
    ctl.hw_raddr = 0; ctl.hw_waddr = 0; ctl.hw_din = 0;

    #2 rst = 1'b1;
    tick(); tick();
    chk("rst_stat", ctl.stat_code, ST_IDLE);
    chk("rst_rd_dat", ctl.rd_dat, 0);
    chk("rst_stat_addr", ctl.stat_addr, 0);
    chk("rst_stat_tid", ctl.stat_table_id, 0);
    chk("rst_yield", ctl.hw_yield, 0);
    chk("rst_drop", ctl.hw_drop, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    rst = 1'b0;
    tick();

    // WRITE t1 a5
    cmd(OP_WRITE, 6'd5, 2'd1, 32'hDEAD_BEEF);
    chk("wr_busy", ctl.stat_code, ST_BUSY);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_sel", mem_sel, 3'b010);
    chk("wr_mem_wa", mem_wa, 5);
    chk("wr_mem_din", mem_din, 32'hDEAD_BEEF);
    tick(); tick();
    chk("wr_ok", ctl.stat_code, ST_OK);

    // READ t1 a5: result 3 cycles after strobe
    cmd(OP_READ, 6'd5, 2'd1, 32'h0);
    chk("rd_mem_re", mem_re, 1);
    chk("rd_mem_sel", mem_sel, 3'b010);
    chk("rd_mem_ra", mem_ra, 5);
    tick(); tick(); tick();
    chk("rd_ok", ctl.stat_code, ST_OK);
    chk("rd_dat", ctl.rd_dat, 32'hDEAD_BEEF);
    chk("rd_stat_addr", ctl.stat_addr, 5);
    chk("rd_stat_tid", ctl.stat_table_id, 1);

    // Range and opcode errors
    base = act_cnt;
    cmd(OP_READ, 6'd50, 2'd0, 32'h0);
    chk("rng_busy", ctl.stat_code, ST_BUSY);
    tick();
    chk("rng_addr_code", ctl.stat_code, ST_ERR_RANGE);
    chk("rng_addr_stat_addr", ctl.stat_addr, 50);
    cmd(OP_WRITE, 6'd3, 2'd3, 32'h1);
    tick();
    chk("rng_tid_code", ctl.stat_code, ST_ERR_RANGE);
    chk("rng_no_access", act_cnt - base, 0);
    cmd(4'd7, 6'd0, 2'd0, 32'h0);
    tick();
    chk("err_op_code", ctl.stat_code, ST_ERR_OP);
    cmd(OP_NOP, 6'd1, 2'd0, 32'h0);
    chk("nop_ok", ctl.stat_code, ST_OK);

    // INIT all tables with 0x5A; a stray strobe mid-INIT is ignored
    base = we_all_cnt;
    cmd(OP_INIT, 6'd0, 2'd0, 32'h0);
    n = 0;
    while ((ctl.stat_code == ST_BUSY) && (n < 300)) begin
      if (n == 5) begin
        ctl.cmnd_stb = 1'b1; ctl.cmnd_op = OP_READ; ctl.cmnd_addr = 6'd9; ctl.cmnd_table_id = 2'd1;
      end else begin
        ctl.cmnd_stb = 1'b0;
      end
      tick();
      n++;
    end
    ctl.cmnd_stb = 1'b0;
    chk("init_cycles", n, 49);
    chk("init_ok", ctl.stat_code, ST_OK);
    chk("init_ignored_stb", ctl.stat_addr, 0);
    chk("init_writes", we_all_cnt - base, 48);
    hw_rd(2'd0, 6'd47, v); chk("init_t0_a47", v, 32'h5A);
    hw_rd(2'd1, 6'd0, v);  chk("init_t1_a0", v, 32'h5A);
    hw_rd(2'd2, 6'd0, v);  chk("init_t2_a0", v, 32'h5A);
    hw_rd(2'd1, 6'd5, v);  chk("init_t1_a5", v, 32'h5A);

    // Starvation: HW holds hw_cs through a WRITE
    ctl.hw_cs = 1'b1; ctl.hw_re = 1'b1; ctl.hw_table_id = 2'd2; ctl.hw_raddr = 6'd0;
    cmd(OP_WRITE, 6'd7, 2'd0, 32'h1234_5678);
    chk("stv_hw_wins_we", mem_we, 0);
    chk("stv_hw_wins_re", mem_re, 1);
    chk("stv_hw_sel", mem_sel, 3'b100);
    chk("stv_hw_dout", ctl.hw_dout, 32'h5A);
    n = 0;
    while (!ctl.hw_yield && (n < 300)) begin
      tick();
      n++;
    end
    chk("stv_yield_after", n, 63);
    chk("stv_drop_before", ctl.hw_drop, 0);
    chk("stv_yield_we", mem_we, 1);
    chk("stv_yield_re", mem_re, 0);
    chk("stv_yield_sel", mem_sel, 3'b001);
    chk("stv_yield_wa", mem_wa, 7);
    chk("stv_yield_din", mem_din, 32'h1234_5678);
    tick();
    chk("stv_drop", ctl.hw_drop, 1);
    chk("stv_yield_1cyc", ctl.hw_yield, 0);
    ctl.hw_cs = 1'b0; ctl.hw_re = 1'b0;
    tick();
    chk("stv_ok", ctl.stat_code, ST_OK);
    hw_rd(2'd0, 6'd7, v); chk("stv_t0_a7", v, 32'h1234_5678);

    // HW write passthrough while idle
    ctl.hw_cs = 1'b1; ctl.hw_we = 1'b1; ctl.hw_table_id = 2'd1; ctl.hw_waddr = 6'd9;
    ctl.hw_din = 32'h0BAD_F00D;
    tick();
    ctl.hw_cs = 1'b0; ctl.hw_we = 1'b0;
    hw_rd(2'd1, 6'd9, v); chk("hw_wr_t1_a9", v, 32'h0BAD_F00D);

    // FILL t0 while HW alternates reads of t1
    base = we_t0_cnt;
    ctl.hw_table_id = 2'd1;
    cmd(OP_FILL, 6'd0, 2'd0, 32'hCAFE_F00D);
    n = 0;
    while ((ctl.stat_code == ST_BUSY) && (n < 400)) begin
      if (n % 2 == 0) begin
        ctl.hw_cs = 1'b1; ctl.hw_re = 1'b1;
        ctl.hw_raddr = (n % 4 == 0) ? 6'd9 : 6'd10;
      end else begin
        ctl.hw_cs = 1'b0; ctl.hw_re = 1'b0;
      end
      tick();
      if (n % 2 == 0) chk("fill_hw_dout", ctl.hw_dout, (n % 4 == 0) ? 32'h0BAD_F00D : 32'h5A);
      n++;
    end
    ctl.hw_cs = 1'b0; ctl.hw_re = 1'b0;
    chk("fill_cycles", n, 97);
    chk("fill_ok", ctl.stat_code, ST_OK);
    chk("fill_writes", we_t0_cnt - base, 48);
    hw_rd(2'd0, 6'd0, v);  chk("fill_t0_a0", v, 32'hCAFE_F00D);
    hw_rd(2'd0, 6'd47, v); chk("fill_t0_a47", v, 32'hCAFE_F00D);
    hw_rd(2'd0, 6'd7, v);  chk("fill_t0_a7", v, 32'hCAFE_F00D);
    hw_rd(2'd1, 6'd0, v);  chk("fill_t1_untouched", v, 32'h5A);

    // Async reset in the middle of a FILL of t2
    base2 = 0;
    cmd(OP_FILL, 6'd0, 2'd2, 32'h1111_2222);
    for (int i = 0; i < 20; i++) tick();
    chk("mid_fill_wa", mem_wa, 20);
    chk("mid_fill_we", mem_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stat", ctl.stat_code, ST_IDLE);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_re", mem_re, 0);
    chk("arst_mem_sel", mem_sel, 0);
    chk("arst_drop", ctl.hw_drop, 0);
    tick();
    rst = 1'b0;
    tick();
    hw_rd(2'd2, 6'd19, v); chk("arst_t2_a19", v, 32'h1111_2222);
    hw_rd(2'd2, 6'd20, v); chk("arst_t2_a20", v, 32'h5A);

    // New FILL after reset
    cmd(OP_FILL, 6'd0, 2'd2, 32'h3333_4444);
    wait_done(n);
    chk("refill_cycles", n + base2, 49);
    chk("refill_ok", ctl.stat_code, ST_OK);
    hw_rd(2'd2, 6'd20, v); chk("refill_t2_a20", v, 32'h3333_4444);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
